// File: rtl/pu_rd_req_gen_if.sv
// Command and read-request bus of pu_rd_req_gen.
// master: the request generator; slave: command source, memory controller and read counter.
interface pu_rd_req_gen_if #(
  parameter int unsigned NUM_PU    = 1,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RD_SIZE_W = 20,
  parameter int unsigned D_TYPE_W  = 2
);
  localparam int unsigned PU_ID_W = $clog2(NUM_PU) + 1;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDR_W-1:0]    cmd_addr;
  logic [ADDR_W-1:0]    cmd_stride;
  logic [RD_SIZE_W-1:0] cmd_size;
  logic [D_TYPE_W-1:0]  cmd_d_type;
  logic                 rd_ready;
  logic                 read_info_full;
  logic                 rd_req;
  logic [ADDR_W-1:0]    rd_req_addr;
  logic [RD_SIZE_W-1:0] rd_req_size;
  logic [PU_ID_W-1:0]   rd_req_pu_id;
  logic [D_TYPE_W-1:0]  rd_req_d_type;
  logic                 busy;
  logic                 done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_stride, cmd_size, cmd_d_type, rd_ready, read_info_full,
    output cmd_ready, rd_req, rd_req_addr, rd_req_size, rd_req_pu_id, rd_req_d_type, busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_stride, cmd_size, cmd_d_type, rd_ready, read_info_full,
    input  cmd_ready, rd_req, rd_req_addr, rd_req_size, rd_req_pu_id, rd_req_d_type, busy, done
  );
endinterface

// File: rtl/pu_rd_req_gen.sv
// Splits one load command into per-PU read bursts, round-robin across PUs.
// Optional request statistics counter enabled by RD_REQ_GEN_STATS_EN.
module pu_rd_req_gen #(
  parameter int unsigned NUM_PU    = 1,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RD_SIZE_W = 20,
  parameter int unsigned D_TYPE_W  = 2,
  parameter int unsigned BURST_MAX = 16,
  localparam int unsigned PU_ID_W  = $clog2(NUM_PU) + 1
) (
  input  logic            clk,
  input  logic            reset,
  pu_rd_req_gen_if.master bus
`ifdef RD_REQ_GEN_STATS_EN
  ,
  output logic [31:0]     stat_req_count
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StFinish} state_e;

  localparam logic [PU_ID_W-1:0]   LastPu   = PU_ID_W'(NUM_PU - 1);
  localparam logic [RD_SIZE_W-1:0] BurstMax = RD_SIZE_W'(BURST_MAX);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]    stride_q, stride_d;
  logic [RD_SIZE_W-1:0] size_q, size_d;
  logic [D_TYPE_W-1:0]  d_type_q, d_type_d;
  logic [RD_SIZE_W-1:0] offset_q, offset_d;
  logic [PU_ID_W-1:0]   pu_q, pu_d;
  // Running pu*stride, avoids a multiplier.
  logic [ADDR_W-1:0]    pu_off_q, pu_off_d;

  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]    rd_req_addr_q, rd_req_addr_d;
  logic [RD_SIZE_W-1:0] rd_req_size_q, rd_req_size_d;
  logic [PU_ID_W-1:0]   rd_req_pu_id_q, rd_req_pu_id_d;
  logic [D_TYPE_W-1:0]  rd_req_d_type_q, rd_req_d_type_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 launch;
  logic                 last_burst;
  logic [RD_SIZE_W-1:0] remaining;
  logic [RD_SIZE_W-1:0] words;

  assign accept     = bus.cmd_valid && cmd_ready_q && (state_q == StIdle);
  assign remaining  = size_q - offset_q;
  assign last_burst = (remaining <= BurstMax);
  assign words      = last_burst ? remaining : BurstMax;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    size_d   = size_q;
    d_type_d = d_type_q;
    offset_d = offset_q;
    pu_d     = pu_q;
    pu_off_d = pu_off_q;
    launch   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d   = bus.cmd_addr;
          stride_d = bus.cmd_stride;
          size_d   = bus.cmd_size;
          d_type_d = bus.cmd_d_type;
          offset_d = '0;
          pu_d     = '0;
          pu_off_d = '0;
          state_d  = (bus.cmd_size == '0) ? StFinish : StIssue;
        end
      end
      StIssue: begin
        if (bus.rd_ready && !bus.read_info_full) begin
          launch = 1'b1;
          if (pu_q == LastPu) begin
            pu_d     = '0;
            pu_off_d = '0;
            offset_d = offset_q + words;
            if (last_burst) begin
              state_d = StFinish;
            end
          end else begin
            pu_d     = pu_q + PU_ID_W'(1);
            pu_off_d = pu_off_q + stride_q;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    rd_req_d        = launch;
    rd_req_addr_d   = rd_req_addr_q;
    rd_req_size_d   = rd_req_size_q;
    rd_req_pu_id_d  = rd_req_pu_id_q;
    rd_req_d_type_d = rd_req_d_type_q;
    if (launch) begin
      rd_req_addr_d   = addr_q + pu_off_q + ADDR_W'(offset_q);
      rd_req_size_d   = words - RD_SIZE_W'(1);
      rd_req_pu_id_d  = pu_q;
      rd_req_d_type_d = d_type_q;
    end
    // Ready only after a full cycle in IDLE, so a held command waits past the done pulse.
    cmd_ready_d = (state_q == StIdle) && (state_d == StIdle);
    busy_d      = (state_d != StIdle);
    done_d      = (state_q == StFinish);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      stride_q        <= '0;
      size_q          <= '0;
      d_type_q        <= '0;
      offset_q        <= '0;
      pu_q            <= '0;
      pu_off_q        <= '0;
      cmd_ready_q     <= 1'b0;
      rd_req_q        <= 1'b0;
      rd_req_addr_q   <= '0;
      rd_req_size_q   <= '0;
      rd_req_pu_id_q  <= '0;
      rd_req_d_type_q <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      stride_q        <= stride_d;
      size_q          <= size_d;
      d_type_q        <= d_type_d;
      offset_q        <= offset_d;
      pu_q            <= pu_d;
      pu_off_q        <= pu_off_d;
      cmd_ready_q     <= cmd_ready_d;
      rd_req_q        <= rd_req_d;
      rd_req_addr_q   <= rd_req_addr_d;
      rd_req_size_q   <= rd_req_size_d;
      rd_req_pu_id_q  <= rd_req_pu_id_d;
      rd_req_d_type_q <= rd_req_d_type_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rd_req        = rd_req_q;
  assign bus.rd_req_addr   = rd_req_addr_q;
  assign bus.rd_req_size   = rd_req_size_q;
  assign bus.rd_req_pu_id  = rd_req_pu_id_q;
  assign bus.rd_req_d_type = rd_req_d_type_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

`ifdef RD_REQ_GEN_STATS_EN
  logic [31:0] stat_q, stat_d;

  // Saturating; survives across commands, cleared only by reset.
  always_comb begin
    stat_d = stat_q;
    if (rd_req_q && (stat_q != 32'hFFFF_FFFF)) begin
      stat_d = stat_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_req_count = stat_q;
`endif

endmodule

// File: tb/tb_pu_rd_req_gen.sv
// Directed bench for pu_rd_req_gen (NUM_PU=4, BURST_MAX=16).
// Also checks the statistics counter when RD_REQ_GEN_STATS_EN is defined.
module tb_pu_rd_req_gen;
  localparam int unsigned NumPu    = 4;
  localparam int unsigned AddrW    = 32;
  localparam int unsigned SizeW    = 20;
  localparam int unsigned DTypeW   = 2;
  localparam int unsigned BurstMax = 16;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  pu_rd_req_gen_if #(
    .NUM_PU   (NumPu),
    .ADDR_W   (AddrW),
    .RD_SIZE_W(SizeW),
    .D_TYPE_W (DTypeW)
  ) bus ();

`ifdef RD_REQ_GEN_STATS_EN
  logic [31:0] stat_req_count;
`endif

  pu_rd_req_gen #(
    .NUM_PU   (NumPu),
    .ADDR_W   (AddrW),
    .RD_SIZE_W(SizeW),
    .D_TYPE_W (DTypeW),
    .BURST_MAX(BurstMax)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef RD_REQ_GEN_STATS_EN
    ,
    .stat_req_count(stat_req_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] s, input int sz,
                          input logic [1:0] dt);
    int waited = 0;
    bus.cmd_addr   = a;
    bus.cmd_stride = s;
    bus.cmd_size   = SizeW'(sz);
    bus.cmd_d_type = dt;
    bus.cmd_valid  = 1'b1;
    while (!bus.cmd_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!bus.cmd_ready) chk("cmd_accept_timeout", 64'(bus.cmd_ready), 64'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Called in the cycle right after acceptance.
  // mode 0: rd_ready held high, pulses back to back; 1: rd_ready toggling;
  // 2: read_info_full high for 5 cycles starting at pulse 3.
  task automatic run_cmd(input int mode, input logic [31:0] a, input logic [31:0] s,
                         input int sz, input logic [1:0] dt, input int stop_after);
    int np = 0;
    int start = cyc;
    int last_cyc = 0;
    int p3_cyc = 0;
    int stall_left = 0;
    int n_exp = ((sz + BurstMax - 1) / BurstMax) * NumPu;
    bit seen_done = 0;
    bit stopped = 0;
    bit prev_ready = bus.rd_ready;
    for (int c = 0; c < 200 && !seen_done && !stopped; c++) begin
      step();
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) bus.read_info_full = 1'b0;
      end
      chk("cmd_ready_low_while_busy", 64'(bus.cmd_ready), 64'd0);
      if (bus.rd_req) begin
        int pu = np % NumPu;
        int beat = np / NumPu;
        int rem = sz - beat * BurstMax;
        logic [31:0] e_addr = a + pu * s + beat * BurstMax;
        int e_size = (rem >= BurstMax) ? BurstMax - 1 : rem - 1;
        chk($sformatf("req%0d_addr", np), 64'(bus.rd_req_addr), 64'(e_addr));
        chk($sformatf("req%0d_size", np), 64'(bus.rd_req_size), 64'(e_size));
        chk($sformatf("req%0d_pu", np), 64'(bus.rd_req_pu_id), 64'(pu));
        chk($sformatf("req%0d_dtype", np), 64'(bus.rd_req_d_type), 64'(dt));
        if (mode == 0) chk($sformatf("req%0d_cycle", np), 64'(cyc), 64'(start + 1 + np));
        if (mode == 1) chk($sformatf("req%0d_after_ready", np), 64'(prev_ready), 64'd1);
        if (mode == 2 && np == 3) chk("req3_after_stall", 64'(cyc), 64'(p3_cyc + 6));
        np++;
        last_cyc = cyc;
        if (mode == 2 && np == 3) begin
          p3_cyc = cyc;
          bus.read_info_full = 1'b1;
          stall_left = 5;
        end
        if (stop_after != 0 && np == stop_after) stopped = 1;
      end
      if (bus.done) begin
        seen_done = 1;
        chk("done_after_last_req", 64'(cyc), 64'(last_cyc + 1));
        chk("busy_low_at_done", 64'(bus.busy), 64'd0);
        chk("no_req_at_done", 64'(bus.rd_req), 64'd0);
      end
      if (mode == 1) begin
        bus.rd_ready = ~bus.rd_ready;
        prev_ready = bus.rd_ready;
      end
    end
    bus.rd_ready = 1'b1;
    bus.read_info_full = 1'b0;
    if (stop_after == 0) begin
      chk("req_count", 64'(np), 64'(n_exp));
      chk("done_seen", 64'(seen_done), 64'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_stride = '0;
    bus.cmd_size = '0;
    bus.cmd_d_type = '0;
    bus.rd_ready = 1'b1;
    bus.read_info_full = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_rd_req", 64'(bus.rd_req), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    step();
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Basic 40-word command, back to back.
    send_cmd(32'h1000, 32'h400, 40, 2'd1);
    chk("busy_t1", 64'(bus.busy), 64'd1);
    run_cmd(0, 32'h1000, 32'h400, 40, 2'd1, 0);
`ifdef RD_REQ_GEN_STATS_EN
    chk("stat_req_count", 64'(stat_req_count), 64'd12);
`endif
    step();
    chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Zero size.
    send_cmd(32'h3000, 32'h10, 0, 2'd2);
    chk("zero_busy_t1", 64'(bus.busy), 64'd1);
    chk("zero_done_t1", 64'(bus.done), 64'd0);
    chk("zero_req_t1", 64'(bus.rd_req), 64'd0);
    step();
    chk("zero_done_t2", 64'(bus.done), 64'd1);
    chk("zero_busy_t2", 64'(bus.busy), 64'd0);
    chk("zero_req_t2", 64'(bus.rd_req), 64'd0);
    step();
    chk("zero_done_t3", 64'(bus.done), 64'd0);
    chk("zero_req_t3", 64'(bus.rd_req), 64'd0);
    step();

    // Info FIFO full stall after pulse 3.
    send_cmd(32'h1000, 32'h400, 40, 2'd1);
    run_cmd(2, 32'h1000, 32'h400, 40, 2'd1, 0);
    step();

    // rd_ready toggling.
    send_cmd(32'h1000, 32'h400, 40, 2'd1);
    run_cmd(1, 32'h1000, 32'h400, 40, 2'd1, 0);
    step();

    // Reset mid-command after pulse 6.
    send_cmd(32'h1000, 32'h400, 40, 2'd1);
    run_cmd(0, 32'h1000, 32'h400, 40, 2'd1, 6);
    reset = 1'b1;
    step();
    chk("mid_rst_rd_req", 64'(bus.rd_req), 64'd0);
    chk("mid_rst_addr", 64'(bus.rd_req_addr), 64'd0);
    chk("mid_rst_size", 64'(bus.rd_req_size), 64'd0);
    chk("mid_rst_pu", 64'(bus.rd_req_pu_id), 64'd0);
    chk("mid_rst_dtype", 64'(bus.rd_req_d_type), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    reset = 1'b0;
    step();
    chk("mid_rst_idle_ready", 64'(bus.cmd_ready), 64'd1);
    send_cmd(32'h1000, 32'h400, 16, 2'd1);
    run_cmd(0, 32'h1000, 32'h400, 16, 2'd1, 0);
    step();

    // Second command held on the input while busy.
    send_cmd(32'h1000, 32'h400, 16, 2'd1);
    bus.cmd_addr   = 32'h2000;
    bus.cmd_stride = 32'h100;
    bus.cmd_size   = SizeW'(8);
    bus.cmd_d_type = 2'd2;
    bus.cmd_valid  = 1'b1;
    run_cmd(0, 32'h1000, 32'h400, 16, 2'd1, 0);
    step();
    chk("held_cmd_ready_after_done", 64'(bus.cmd_ready), 64'd1);
    step();
    chk("held_cmd_busy", 64'(bus.busy), 64'd1);
    bus.cmd_valid = 1'b0;
    run_cmd(0, 32'h2000, 32'h100, 8, 2'd2, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pu_rd_req_gen.md
# pu_rd_req_gen

Read-request generator that sits directly upstream of the buffer read counter. It accepts one load command per layer tile and splits it into per-PU memory read bursts, interleaved round-robin across PUs. Each burst is issued to the memory controller and, in the same cycle, announced to the buffer read counter through the `rd_req`/`rd_req_size`/`rd_req_pu_id`/`rd_req_d_type` bus. Issue stalls while the counter's read-info FIFO reports full.

## Interface

Parameters:
- `NUM_PU`, 1: number of processing units.
- `ADDR_W`, 32: word-address width.
- `RD_SIZE_W`, 20: request size / command size width.
- `D_TYPE_W`, 2: data-type tag width.
- `BURST_MAX`, 16: maximum words per burst, power of two, ≥1.
- `PU_ID_W`: localparam, `C_LOG_2(NUM_PU)+1`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both this and `cmd_valid` are high.
- `cmd_addr` in ADDR_W: base word address of the PU0 region.
- `cmd_stride` in ADDR_W: word offset between consecutive PU regions.
- `cmd_size` in RD_SIZE_W: words per PU.
- `cmd_d_type` in D_TYPE_W: data-type tag copied to every request.
- `rd_ready` in 1: memory controller can take a request this cycle.
- `read_info_full` in 1: the buffer read counter's info FIFO is full.
- `rd_req` out 1: one-cycle strobe per request.
- `rd_req_addr` out ADDR_W: burst start word address.
- `rd_req_size` out RD_SIZE_W: burst words minus 1.
- `rd_req_pu_id` out PU_ID_W: target PU.
- `rd_req_d_type` out D_TYPE_W: latched `cmd_d_type`.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.

## Operation

- FSM states:
  - IDLE: `cmd_ready`=1. On accept, latch all `cmd_*` fields, clear `offset` and `pu`, then go to ISSUE. If `cmd_size`==0, go to FINISH instead.
  - ISSUE: "launch" occurs when `rd_ready`=1 and `read_info_full`=0. Otherwise hold all state, with no skip and no duplicate.
  - FINISH: assert `done` for one cycle, then return to IDLE.
- Burst size: `words = min(BURST_MAX, size − offset)`. Drive `rd_req_size` = `words−1`.
- Launch address: `addr + pu*stride + offset`. Arithmetic is modulo 2^ADDR_W; wrap-around is silent. Compute `pu*stride` incrementally with an accumulator, not a multiplier.
- Order within a launch sequence:
  - PU inner loop: `pu` runs 0..NUM_PU−1.
  - Offset outer loop: after PU NUM_PU−1, `offset += words` and `pu` resets to 0.
  - When `offset + words == size` at `pu == NUM_PU−1`, that launch is the last one and the FSM goes to FINISH.
- Total requests per command: `ceil(size/BURST_MAX) * NUM_PU`. Every PU receives identical burst sizes in the same order, which the counter's `pu_id == NUM_PU−1` last-detection depends on.
- `busy` is high in ISSUE and FINISH.
- `cmd_valid` arriving outside IDLE is not accepted; the command stays pending on the input.
- Reset, including mid-command: FSM goes to IDLE, the in-flight command is discarded, and all outputs go to 0.

## Timing

- All outputs are registered.
- Reset values: `cmd_ready`=0 during reset and 1 from the first cycle after reset deasserts. Every other output is 0.
- Command accepted at cycle T:
  - State is ISSUE from T+1.
  - The first launch can occur at T+1.
  - `rd_req` and its fields are visible at T+2.
- Throughput: one request per cycle while the launch condition holds.
- A launch at cycle L produces the `rd_req` pulse at L+1. Fields hold their value until the next pulse.
- `done`: asserted in the cycle after the final `rd_req` pulse. `busy` drops in the same cycle as `done`.
- Zero-size command: `done` at T+2, with no `rd_req` pulse.
- `read_info_full` is sampled as given. The counter's FIFO has a depth of 128, which covers its 1-cycle registered-flag lag.

## Configuration

- `RD_REQ_GEN_STATS_EN` defined:
  - Adds output `stat_req_count` [31:0], reset to 0.
  - Increments on every `rd_req` pulse and saturates at 0xFFFFFFFF.
  - It is not cleared by new commands, only by reset.
- `RD_REQ_GEN_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan

- NUM_PU=4, BURST_MAX=16, addr=0x1000, stride=0x400, size=40, d_type=1, `rd_ready`=1 → 12 consecutive pulses:
  - Pulses 1–4: addrs 0x1000/0x1400/0x1800/0x1C00, size 15, pu 0..3.
  - Pulses 5–8: 0x1010…, size 15.
  - Pulses 9–12: 0x1020…, size 7.
  - `done` one cycle after pulse 12.
- size=0 → no `rd_req`. `done` is high exactly at T+2, and `busy` is high only at T+1.
- Same command as the first scenario, with `read_info_full` held high for 5 cycles after pulse 3 → no pulses during the stall. Pulse 4 is pu3 @0x1C00 and the sequence completes with 12 pulses total.
- `rd_ready` toggled 1,0,1,0… → one pulse per launch cycle, order identical to the first scenario, none duplicated.
- `reset` asserted after pulse 6 → next cycle all outputs are 0 and the FSM is in IDLE. A new size=16 command then yields 4 pulses, size 15, starting at pu0.
- `cmd_valid` held with a second command while busy → `cmd_ready`=0 until after `done`. The second command is accepted the cycle after `done`.
- With `RD_REQ_GEN_STATS_EN`: after the first scenario, `stat_req_count`=12.
